// File: rtl/fifo_stream_reader.sv
// Read-side engine for a non-FWFT FIFO: pops words into a 2-entry skid buffer and
// presents them as a valid/ready stream with end-of-frame tracking and a frame counter.
module fifo_stream_reader #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    output logic                    fifo_rd_o,
    input  logic [P_DATA_WIDTH:0]   fifo_data_i,
    input  logic                    fifo_empty_i,
    output logic                    m_valid_o,
    output logic [P_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    input  logic                    m_ready_i,
    output logic                    in_frame_o,
    output logic [P_CNT_WIDTH-1:0]  frame_cnt_o
);

    typedef enum logic {
        S_IDLE,
        S_IN_FRAME
    } state_t;

    logic [1:0]             r_occ;
    logic                   r_infl;
    logic [P_DATA_WIDTH:0]  r_head;
    logic [P_DATA_WIDTH:0]  r_tail;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [P_CNT_WIDTH-1:0] r_frame_cnt;

    logic       w_pop;
    logic [2:0] w_level;
    logic [1:0] w_occ_after_pop;

    assign m_valid_o       = (r_occ != 2'd0);
    assign m_data_o        = r_head[P_DATA_WIDTH-1:0];
    assign m_last_o        = r_head[P_DATA_WIDTH];
    assign w_pop           = m_valid_o & m_ready_i;
    // Words held or arriving after this cycle's pop; a read is allowed only while below 2.
    assign w_level         = {1'b0, r_occ} + {2'b00, r_infl} - {2'b00, w_pop};
    assign fifo_rd_o       = ~fifo_empty_i & (w_level < 3'd2);
    assign w_occ_after_pop = r_occ - {1'b0, w_pop};
    assign in_frame_o      = (r_state == S_IN_FRAME);
    assign frame_cnt_o     = r_frame_cnt;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            // NOTE: the data registers are reset too, so m_data_o/m_last_o read 0 after reset
            // and no stale word can reappear once the buffer refills.
            r_occ  <= 2'd0;
            r_infl <= 1'b0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_infl <= fifo_rd_o;
            r_occ  <= w_level[1:0];
            if (w_pop && (r_occ == 2'd2)) begin
                r_head <= r_tail;
            end
            // The RAM output is only meaningful the cycle after a read was issued.
            if (r_infl) begin
                if (w_occ_after_pop == 2'd0) begin
                    r_head <= fifo_data_i;
                end else begin
                    r_tail <= fifo_data_i;
                end
            end
        end
    end

    always_comb begin
        // NOTE: combinational next-state takes its hold value first so no latch is inferred.
        w_state_nxt = r_state;
        if (w_pop) begin
            w_state_nxt = m_last_o ? S_IDLE : S_IN_FRAME;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state     <= S_IDLE;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop && m_last_o) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized bench for fifo_stream_reader: a behavioural FIFO plus an ordered-stream
// and frame-count reference model; each scenario task checks its own results.
module tb_fifo_stream_reader;

    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          fifo_rd;
    logic [DW:0]   fifo_data;
    logic          fifo_empty;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic          in_frame;
    logic [CW-1:0] frame_cnt;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .P_DATA_WIDTH (DW),
        .P_CNT_WIDTH  (CW)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .fifo_rd_o    (fifo_rd),
        .fifo_data_i  (fifo_data),
        .fifo_empty_i (fifo_empty),
        .m_valid_o    (m_valid),
        .m_data_o     (m_data),
        .m_last_o     (m_last),
        .m_ready_i    (m_ready),
        .in_frame_o   (in_frame),
        .frame_cnt_o  (frame_cnt)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int first_rd_cyc, first_valid_cyc;
    int reads = 0, pops = 0;
    int rd_empty_err = 0, over_err = 0, stab_err = 0;
    int model_cnt = 0;
    bit model_in_frame = 1'b0;
    bit prev_stall = 1'b0;
    logic [DW:0] prev_word;
    logic [DW:0] fifo_q[$];
    logic [DW:0] exp_q[$];
    logic [DW:0] got_q[$];
    int          pop_cyc_q[$];

    task automatic push_word(input logic [DW-1:0] d, input logic last);
        fifo_q.push_back({last, d});
        exp_q.push_back({last, d});
    endtask

    // One clock: sample the DUT mid-cycle, advance the FIFO and the reference model.
    task automatic tick();
        bit          rd, pp;
        logic [DW:0] w;
        fifo_empty = (fifo_q.size() == 0);
        #1;
        if (fifo_rd && fifo_empty) rd_empty_err++;
        if (prev_stall && (!m_valid || {m_last, m_data} !== prev_word)) stab_err++;
        if (fifo_rd && first_rd_cyc < 0) first_rd_cyc = cyc;
        if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        rd = fifo_rd && !fifo_empty;
        pp = m_valid && m_ready;
        w  = {m_last, m_data};
        prev_stall = m_valid && !m_ready && rstn;
        prev_word  = w;
        @(posedge clk);
        #1;
        if (!rstn) begin
            fifo_q.delete();
            fifo_data = '0;
            reads = 0;
            pops = 0;
            model_cnt = 0;
            model_in_frame = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (rd) begin
                fifo_data = fifo_q.pop_front();
                reads++;
            end
            if (pp) begin
                pops++;
                got_q.push_back(w);
                pop_cyc_q.push_back(cyc);
                model_in_frame = !w[DW];
                if (w[DW]) model_cnt = (model_cnt + 1) % (1 << CW);
            end
            if (reads - pops > 2) over_err++;
        end
        fifo_empty = (fifo_q.size() == 0);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && got_q.size() < exp_q.size(); i++) tick();
    endtask

    task automatic start_test();
        got_q.delete();
        exp_q.delete();
        pop_cyc_q.delete();
        first_rd_cyc = -1;
        first_valid_cyc = -1;
        rd_empty_err = 0;
        over_err = 0;
        stab_err = 0;
    endtask

    task automatic test_reset();
        start_test();
        rstn = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors += 3;
            if (fifo_rd !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_rd cyc=%0d got=%b exp=0", i, fifo_rd);
            end
            if (m_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_valid cyc=%0d got=%b exp=0", i, m_valid);
            end
            if (frame_cnt !== '0) begin
                miscompares++;
                $display("FAIL reset_cnt cyc=%0d got=%0d exp=0", i, frame_cnt);
            end
        end
    endtask

    task automatic test_frame();
        start_test();
        for (int i = 0; i < 4; i++) push_word(DW'(32'h11 + i), i == 3);
        m_ready = 1'b1;
        drain(30);
        vectors++;
        if (got_q.size() != 4) begin
            miscompares++;
            $display("FAIL frame_count_words got=%0d exp=4", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL frame_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (first_valid_cyc - first_rd_cyc != 2) begin
            miscompares++;
            $display("FAIL frame_latency got=%0d exp=2", first_valid_cyc - first_rd_cyc);
        end
        for (int i = 1; i < pop_cyc_q.size(); i++) begin
            vectors++;
            if (pop_cyc_q[i] != pop_cyc_q[i-1] + 1) begin
                miscompares++;
                $display("FAIL frame_b2b[%0d] got_gap=%0d exp=1", i, pop_cyc_q[i] - pop_cyc_q[i-1]);
            end
        end
        vectors += 2;
        if (frame_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL frame_cnt got=%0d exp=1", frame_cnt);
        end
        if (in_frame !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_in_frame got=%b exp=0", in_frame);
        end
    endtask

    task automatic test_toggle_ready();
        start_test();
        for (int i = 0; i < 8; i++) push_word($urandom, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 60 && got_q.size() < exp_q.size(); i++) begin
            m_ready = i[0];
            tick();
        end
        m_ready = 1'b0;
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL toggle_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL toggle_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        vectors += 5;
        if (over_err != 0) begin
            miscompares++;
            $display("FAIL toggle_overread got=%0d exp=0", over_err);
        end
        if (rd_empty_err != 0) begin
            miscompares++;
            $display("FAIL toggle_rd_empty got=%0d exp=0", rd_empty_err);
        end
        if (stab_err != 0) begin
            miscompares++;
            $display("FAIL toggle_stable got=%0d exp=0", stab_err);
        end
        if (frame_cnt !== CW'(model_cnt)) begin
            miscompares++;
            $display("FAIL toggle_cnt got=%0d exp=%0d", frame_cnt, model_cnt);
        end
        if (in_frame !== model_in_frame) begin
            miscompares++;
            $display("FAIL toggle_in_frame got=%b exp=%b", in_frame, model_in_frame);
        end
    endtask

    task automatic test_stall();
        int reads0;
        start_test();
        for (int i = 0; i < 16; i++) push_word($urandom, 1'(i == 15));
        reads0 = reads;
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        vectors += 3;
        if (reads - reads0 != 2) begin
            miscompares++;
            $display("FAIL stall_reads got=%0d exp=2", reads - reads0);
        end
        if (m_valid !== 1'b1 || {m_last, m_data} !== exp_q[0]) begin
            miscompares++;
            $display("FAIL stall_head got=%b/%h exp=1/%h", m_valid, {m_last, m_data}, exp_q[0]);
        end
        if (stab_err != 0) begin
            miscompares++;
            $display("FAIL stall_stable got=%0d exp=0", stab_err);
        end
        m_ready = 1'b1;
        drain(40);
        vectors++;
        if (got_q.size() != 16) begin
            miscompares++;
            $display("FAIL stall_count got=%0d exp=16", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL stall_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        for (int i = 1; i < pop_cyc_q.size(); i++) begin
            vectors++;
            if (pop_cyc_q[i] != pop_cyc_q[i-1] + 1) begin
                miscompares++;
                $display("FAIL stall_b2b[%0d] got_gap=%0d exp=1", i, pop_cyc_q[i] - pop_cyc_q[i-1]);
            end
        end
        vectors++;
        if (over_err != 0 || rd_empty_err != 0) begin
            miscompares++;
            $display("FAIL stall_reads_legal got=%0d/%0d exp=0/0", over_err, rd_empty_err);
        end
    endtask

    task automatic test_single_and_wrap();
        int cnt0, in_frame_err, n;
        start_test();
        cnt0 = model_cnt;
        in_frame_err = 0;
        for (int i = 0; i < 3; i++) push_word($urandom, 1'b1);
        m_ready = 1'b1;
        for (int i = 0; i < 20 && got_q.size() < exp_q.size(); i++) begin
            tick();
            if (in_frame !== 1'b0) in_frame_err++;
        end
        vectors += 2;
        if (in_frame_err != 0) begin
            miscompares++;
            $display("FAIL single_in_frame got=%0d cycles high exp=0", in_frame_err);
        end
        if (frame_cnt !== CW'(cnt0 + 3)) begin
            miscompares++;
            $display("FAIL single_cnt got=%0d exp=%0d", frame_cnt, CW'(cnt0 + 3));
        end
        n = (1 << CW) - 1 - model_cnt;
        for (int i = 0; i < n; i++) push_word($urandom, 1'b1);
        drain(n + 20);
        vectors++;
        if (frame_cnt !== {CW{1'b1}}) begin
            miscompares++;
            $display("FAIL wrap_max got=%0d exp=%0d", frame_cnt, (1 << CW) - 1);
        end
        push_word($urandom, 1'b1);
        drain(20);
        vectors += 2;
        if (frame_cnt !== '0) begin
            miscompares++;
            $display("FAIL wrap_zero got=%0d exp=0", frame_cnt);
        end
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL wrap_words got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        start_test();
        for (int i = 0; i < 8; i++) push_word($urandom, 1'(i == 7));
        m_ready = 1'b1;
        for (int i = 0; i < 20 && got_q.size() < 2; i++) tick();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        vectors++;
        if (in_frame !== 1'b1 || m_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_setup got=%b/%b exp=1/1", in_frame, m_valid);
        end
        rstn = 1'b0;
        tick();
        vectors++;
        if ({fifo_rd, m_valid, m_last, m_data, in_frame, frame_cnt} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs got=rd%b v%b l%b d%h f%b c%0d exp=all0",
                     fifo_rd, m_valid, m_last, m_data, in_frame, frame_cnt);
        end
        rstn = 1'b1;
        start_test();
        push_word(32'hA5A5_0001, 1'b0);
        push_word(32'hA5A5_0002, 1'b1);
        m_ready = 1'b1;
        drain(20);
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (got_q.size() != 2) begin
            miscompares++;
            $display("FAIL mid_post_count got=%0d exp=2", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL mid_post_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (frame_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL mid_post_cnt got=%0d exp=1", frame_cnt);
        end
    endtask

    initial begin
        rstn = 1'b0;
        m_ready = 1'b0;
        fifo_data = '0;
        fifo_empty = 1'b1;
        test_reset();
        test_frame();
        test_toggle_ready();
        test_stall();
        test_single_and_wrap();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
